// File: rtl/vending_machine_multi.sv
// ---------------------------------------------------------------------------
// vending_machine_multi
//
// Multi-product vending controller. It collects nickel, dime and quarter credit,
// vends one of NUM_PROD products at per-product prices and keeps a stock counter
// for each product. Leftover credit is returned one nickel per cycle.
// All amounts are in nickel units (1 unit = 5 cents).
//
// Optional feature: define VM_RESTOCK_EN to add the restock_i/restock_prod_i
// ports. A restock request reloads one product's stock to STOCK_INIT.
//
// Ports
//   clk_i          clock
//   rst_i          synchronous reset, active-high
//   nickle_i       5c coin this cycle
//   dime_i         10c coin this cycle
//   quarter_i      25c coin this cycle
//   sel_valid_i    product selection strobe
//   sel_i          selected product index
//   cancel_i       refund request
//   restock_i      (VM_RESTOCK_EN) reload stock of restock_prod_i
//   restock_prod_i (VM_RESTOCK_EN) product to reload
//   credit_o       current credit, nickels
//   coin_reject_o  coin(s) of previous cycle returned
//   vend_valid_o   one-cycle vend pulse
//   vend_prod_o    product being vended (valid with vend_valid_o)
//   change_o       one nickel returned this cycle
//   busy_o         high while vending or returning change
//   err_o          one-cycle pulse: rejected selection
//   sold_out_o     bit k set when product k has no stock
// ---------------------------------------------------------------------------
module vending_machine_multi #(
    parameter int NUM_PROD   = 4,
    parameter int CREDIT_W   = 6,
    parameter logic [NUM_PROD*CREDIT_W-1:0] PRICE_TABLE = {6'd8, 6'd6, 6'd5, 6'd4},
    parameter int MAX_CREDIT = 20,
    parameter int STOCK_W    = 4,
    parameter int STOCK_INIT = 8,
    localparam int SEL_W     = (NUM_PROD > 1) ? $clog2(NUM_PROD) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                nickle_i,
    input  logic                dime_i,
    input  logic                quarter_i,
    input  logic                sel_valid_i,
    input  logic [SEL_W-1:0]    sel_i,
    input  logic                cancel_i,
`ifdef VM_RESTOCK_EN
    input  logic                restock_i,
    input  logic [SEL_W-1:0]    restock_prod_i,
`endif
    output logic [CREDIT_W-1:0] credit_o,
    output logic                coin_reject_o,
    output logic                vend_valid_o,
    output logic [SEL_W-1:0]    vend_prod_o,
    output logic                change_o,
    output logic                busy_o,
    output logic                err_o,
    output logic [NUM_PROD-1:0] sold_out_o
);

    localparam int SEL_N = 2 ** SEL_W;
    localparam logic [STOCK_W-1:0]  STOCK_INIT_V = STOCK_W'(STOCK_INIT);
    localparam logic [CREDIT_W:0]   MAX_CREDIT_V = (CREDIT_W + 1)'(MAX_CREDIT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CREDIT = 2'd1,
        ST_VEND   = 2'd2,
        ST_CHANGE = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [CREDIT_W-1:0]   credit_q, credit_d;
    logic                  coin_reject_q, coin_reject_d;
    logic                  err_q, err_d;
    logic [SEL_W-1:0]      vend_prod_q, vend_prod_d;
    logic                  vend_accept;

    // Coin decode: a coin only counts when exactly one input is high.
    logic [1:0]            coin_cnt;
    logic                  any_coin;
    logic                  one_coin;
    logic [CREDIT_W-1:0]   coin_val;
    logic                  coin_fits;

    assign coin_cnt  = {1'b0, nickle_i} + {1'b0, dime_i} + {1'b0, quarter_i};
    assign any_coin  = nickle_i | dime_i | quarter_i;
    assign one_coin  = (coin_cnt == 2'd1);
    assign coin_val  = quarter_i ? CREDIT_W'(5) : (dime_i ? CREDIT_W'(2) : CREDIT_W'(1));
    assign coin_fits = ({1'b0, credit_q} + {1'b0, coin_val}) <= MAX_CREDIT_V;

    // Lookup tables padded to the full index range so that out-of-range
    // selections read zero instead of indexing past the product arrays.
    logic [CREDIT_W-1:0]   price_lut [SEL_N];
    logic [STOCK_W-1:0]    stock_lut [SEL_N];
    logic [STOCK_W-1:0]    stock_cur [NUM_PROD];

    genvar gi;
    generate
        for (gi = 0; gi < SEL_N; gi++) begin : g_lut
            if (gi < NUM_PROD) begin : g_real
                assign price_lut[gi] = PRICE_TABLE[gi*CREDIT_W +: CREDIT_W];
                assign stock_lut[gi] = stock_cur[gi];
            end else begin : g_pad
                assign price_lut[gi] = '0;
                assign stock_lut[gi] = '0;
            end
        end
    endgenerate

    logic                  sel_in_range;
    logic                  sel_ok;

    assign sel_in_range = (32'(sel_i) < NUM_PROD);
    assign sel_ok       = sel_in_range && (stock_lut[sel_i] != '0)
                          && (credit_q >= price_lut[sel_i]);

    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        coin_reject_d = 1'b0;
        err_d         = 1'b0;
        vend_prod_d   = vend_prod_q;
        vend_accept   = 1'b0;
        case (state_q)
            ST_IDLE, ST_CREDIT: begin
                if (cancel_i && (credit_q != '0)) begin
                    // Refund wins over everything; any coin is handed back.
                    state_d       = ST_CHANGE;
                    coin_reject_d = any_coin;
                end else begin
                    if (sel_valid_i && sel_ok) begin
                        vend_accept   = 1'b1;
                        state_d       = ST_VEND;
                        credit_d      = credit_q - price_lut[sel_i];
                        vend_prod_d   = sel_i;
                        coin_reject_d = any_coin;
                    end else begin
                        // A rejected selection does not block the coin path.
                        err_d = sel_valid_i;
                        if (one_coin && coin_fits) begin
                            credit_d = credit_q + coin_val;
                            state_d  = ST_CREDIT;
                        end else begin
                            coin_reject_d = any_coin;
                        end
                    end
                end
            end
            ST_VEND: begin
                coin_reject_d = any_coin;
                state_d       = (credit_q != '0) ? ST_CHANGE : ST_IDLE;
            end
            ST_CHANGE: begin
                coin_reject_d = any_coin;
                if (credit_q <= CREDIT_W'(1)) begin
                    credit_d = '0;
                    state_d  = ST_IDLE;
                end else begin
                    credit_d = credit_q - CREDIT_W'(1);
                end
            end
            default: begin
                state_d  = ST_IDLE;
                credit_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            credit_q      <= '0;
            coin_reject_q <= 1'b0;
            err_q         <= 1'b0;
            vend_prod_q   <= '0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            coin_reject_q <= coin_reject_d;
            err_q         <= err_d;
            vend_prod_q   <= vend_prod_d;
        end
    end

    // Per-product stock counters and sold-out flags.
    generate
        for (gi = 0; gi < NUM_PROD; gi++) begin : g_stock
            logic [STOCK_W-1:0] stock_q, stock_d;
            logic               sold_q;
            logic               dec_hit;
            logic               restock_hit;

            assign dec_hit = vend_accept && (32'(sel_i) == gi);
`ifdef VM_RESTOCK_EN
            assign restock_hit = restock_i && (32'(restock_prod_i) == gi);
`else
            assign restock_hit = 1'b0;
`endif

            // Restock overrides a same-cycle vend of the same product.
            always_comb begin
                stock_d = stock_q;
                if (restock_hit) begin
                    stock_d = STOCK_INIT_V;
                end else if (dec_hit && (stock_q != '0)) begin
                    stock_d = stock_q - STOCK_W'(1);
                end
            end

            // The flag is loaded from the next stock value so it always
            // agrees with the counter it describes.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    stock_q <= STOCK_INIT_V;
                    sold_q  <= 1'b0;
                end else begin
                    stock_q <= stock_d;
                    sold_q  <= (stock_d == '0);
                end
            end

            assign stock_cur[gi]  = stock_q;
            assign sold_out_o[gi] = sold_q;
        end
    endgenerate

    assign credit_o      = credit_q;
    assign coin_reject_o = coin_reject_q;
    assign err_o         = err_q;
    assign vend_prod_o   = vend_prod_q;
    assign vend_valid_o  = (state_q == ST_VEND);
    assign change_o      = (state_q == ST_CHANGE);
    assign busy_o        = (state_q == ST_VEND) || (state_q == ST_CHANGE);

endmodule

// File: tb/tb_vending_machine_multi.sv
// ---------------------------------------------------------------------------
// tb_vending_machine_multi
//
// Directed scenarios followed by a randomized run, all checked cycle by cycle
// against a behavioural model. The model tracks credit and stock as plain
// integers and keeps a script of the output cycles still to come after a vend
// or refund (vend pulse, then one entry per returned nickel).
// ---------------------------------------------------------------------------
module tb_vending_machine_multi;

    localparam int NP = 4;
    localparam int MAXC = 20;
    localparam int SINIT = 8;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_i, nickle_i, dime_i, quarter_i, sel_valid_i, cancel_i;
    logic [1:0] sel_i;
    logic [5:0] credit_o;
    logic       coin_reject_o, vend_valid_o, change_o, busy_o, err_o;
    logic [1:0] vend_prod_o;
    logic [3:0] sold_out_o;
`ifdef VM_RESTOCK_EN
    logic       restock_i;
    logic [1:0] restock_prod_i;
`endif

    vending_machine_multi dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .nickle_i      (nickle_i),
        .dime_i        (dime_i),
        .quarter_i     (quarter_i),
        .sel_valid_i   (sel_valid_i),
        .sel_i         (sel_i),
        .cancel_i      (cancel_i),
`ifdef VM_RESTOCK_EN
        .restock_i     (restock_i),
        .restock_prod_i(restock_prod_i),
`endif
        .credit_o      (credit_o),
        .coin_reject_o (coin_reject_o),
        .vend_valid_o  (vend_valid_o),
        .vend_prod_o   (vend_prod_o),
        .change_o      (change_o),
        .busy_o        (busy_o),
        .err_o         (err_o),
        .sold_out_o    (sold_out_o)
    );

    int total = 0;
    int bad = 0;

    // Reference model state
    int price [NP] = '{4, 5, 6, 8};
    int m_credit;
    int m_stock [NP];
    int m_prod;
    bit m_vend, m_chg, m_rej, m_err;
    typedef struct {
        bit vend;
        bit chg;
        int credit;
    } ent_t;
    ent_t sched [$];
    bit rs;
    int rsp;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Predict the outputs of the next cycle from the inputs of this one.
    task automatic model_step(input bit r, input bit n, input bit d, input bit qt,
                              input bit sv, input int s, input bit c);
        int   nc, val;
        bit   accepted;
        ent_t e;
        m_rej = 0;
        m_err = 0;
        if (r) begin
            m_credit = 0;
            m_vend   = 0;
            m_chg    = 0;
            for (int k = 0; k < NP; k++) m_stock[k] = SINIT;
            sched.delete();
            return;
        end
        nc  = int'(n) + int'(d) + int'(qt);
        val = qt ? 5 : (d ? 2 : 1);
        if (m_vend || m_chg) begin
            m_rej = (nc > 0);
            if (sched.size() > 0) begin
                e = sched.pop_front();
                m_vend = e.vend; m_chg = e.chg; m_credit = e.credit;
            end else begin
                m_vend = 0; m_chg = 0; m_credit = 0;
            end
        end else if (c && m_credit > 0) begin
            m_rej = (nc > 0);
            m_chg = 1;
            for (int v = m_credit - 1; v >= 1; v--) sched.push_back('{0, 1, v});
        end else begin
            accepted = 0;
            if (sv) begin
                if (s < NP && m_stock[s] > 0 && m_credit >= price[s]) begin
                    accepted = 1;
                    m_stock[s]--;
                    m_credit = m_credit - price[s];
                    m_vend = 1;
                    m_prod = s;
                    for (int v = m_credit; v >= 1; v--) sched.push_back('{0, 1, v});
                end else begin
                    m_err = 1;
                end
            end
            if (accepted) m_rej = (nc > 0);
            else if (nc == 1) begin
                if (m_credit + val <= MAXC) m_credit += val;
                else m_rej = 1;
            end else if (nc > 1) m_rej = 1;
        end
`ifdef VM_RESTOCK_EN
        if (rs && rsp < NP) m_stock[rsp] = SINIT;
`endif
    endtask

    task automatic check_all(input string tag);
        int so;
        so = 0;
        for (int k = 0; k < NP; k++) if (m_stock[k] == 0) so |= (1 << k);
        check({tag, ".credit"}, int'(credit_o), m_credit);
        check({tag, ".reject"}, int'(coin_reject_o), int'(m_rej));
        check({tag, ".vend"}, int'(vend_valid_o), int'(m_vend));
        if (m_vend) check({tag, ".prod"}, int'(vend_prod_o), m_prod);
        check({tag, ".change"}, int'(change_o), int'(m_chg));
        check({tag, ".busy"}, int'(busy_o), int'(m_vend || m_chg));
        check({tag, ".err"}, int'(err_o), int'(m_err));
        check({tag, ".soldout"}, int'(sold_out_o), so);
    endtask

    task automatic cyc(input string tag, input bit r, input bit n, input bit d,
                       input bit qt, input bit sv, input int s, input bit c);
        logic [1:0] s2;
        s2 = 2'(s);
        rst_i = r; nickle_i = n; dime_i = d; quarter_i = qt;
        sel_valid_i = sv; sel_i = s2; cancel_i = c;
`ifdef VM_RESTOCK_EN
        restock_i = rs; restock_prod_i = 2'(rsp);
`endif
        @(posedge clk);
        model_step(r, n, d, qt, sv, s, c);
        #1;
        check_all(tag);
        rst_i = 0; nickle_i = 0; dime_i = 0; quarter_i = 0;
        sel_valid_i = 0; sel_i = 0; cancel_i = 0; rs = 0;
`ifdef VM_RESTOCK_EN
        restock_i = 0;
`endif
        $display("cyc %s credit=%0d rej=%0b vend=%0b chg=%0b err=%0b so=%b",
                 tag, credit_o, coin_reject_o, vend_valid_o, change_o, err_o, sold_out_o);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && (m_vend || m_chg); i++) cyc(tag, 0, 0, 0, 0, 0, 0, 0);
        check({tag, ".drained"}, int'(busy_o), 0);
    endtask

    initial begin
        int rr, cp, s;
        bit n, d, qt, sv, c, r;
        rst_i = 1; nickle_i = 0; dime_i = 0; quarter_i = 0;
        sel_valid_i = 0; sel_i = 0; cancel_i = 0; rs = 0; rsp = 0;
        m_prod = 0;
`ifdef VM_RESTOCK_EN
        restock_i = 0; restock_prod_i = 0;
`endif
        cyc("reset", 1, 0, 0, 0, 0, 0, 0);
        check("reset.credit0", int'(credit_o), 0);
        check("reset.soldout0", int'(sold_out_o), 0);
        check("reset.busy0", int'(busy_o), 0);

        // 1: quarter, buy product 0 (20c), one nickel back
        cyc("t1.quarter", 0, 0, 0, 1, 0, 0, 0);
        check("t1.credit5", int'(credit_o), 5);
        cyc("t1.sel0", 0, 0, 0, 0, 1, 0, 0);
        check("t1.vend", int'(vend_valid_o), 1);
        check("t1.prod0", int'(vend_prod_o), 0);
        check("t1.rem1", int'(credit_o), 1);
        cyc("t1.chg", 0, 0, 0, 0, 0, 0, 0);
        check("t1.change", int'(change_o), 1);
        cyc("t1.idle", 0, 0, 0, 0, 0, 0, 0);
        check("t1.credit0", int'(credit_o), 0);
        check("t1.nochange", int'(change_o), 0);

        // 2: credit ceiling
        for (int i = 0; i < 4; i++) cyc("t2.quarter", 0, 0, 0, 1, 0, 0, 0);
        check("t2.credit20", int'(credit_o), 20);
        cyc("t2.fifth", 0, 0, 0, 1, 0, 0, 0);
        check("t2.reject", int'(coin_reject_o), 1);
        check("t2.credit_kept", int'(credit_o), 20);
        cyc("t2.cancel", 0, 0, 0, 0, 0, 0, 1);
        drain("t2.drain");

        // 3: insufficient credit, then refund of 10c
        cyc("t3.dime", 0, 0, 1, 0, 0, 0, 0);
        cyc("t3.sel3", 0, 0, 0, 0, 1, 3, 0);
        check("t3.err", int'(err_o), 1);
        check("t3.credit2", int'(credit_o), 2);
        cyc("t3.cancel", 0, 0, 0, 0, 0, 0, 1);
        check("t3.chg_a", int'(change_o), 1);
        cyc("t3.chg", 0, 0, 0, 0, 0, 0, 0);
        check("t3.chg_b", int'(change_o), 1);
        cyc("t3.idle", 0, 0, 0, 0, 0, 0, 0);
        check("t3.credit0", int'(credit_o), 0);

        // 4: two coins at once
        cyc("t4.nd", 0, 1, 1, 0, 0, 0, 0);
        check("t4.reject", int'(coin_reject_o), 1);
        check("t4.credit0", int'(credit_o), 0);

        // 5: sell out product 1
        for (int i = 0; i < 8; i++) begin
            cyc("t5.quarter", 0, 0, 0, 1, 0, 0, 0);
            cyc("t5.sel1", 0, 0, 0, 0, 1, 1, 0);
            cyc("t5.after", 0, 0, 0, 0, 0, 0, 0);
        end
        check("t5.soldout1", int'(sold_out_o[1]), 1);
        cyc("t5.quarter9", 0, 0, 0, 1, 0, 0, 0);
        cyc("t5.sel9", 0, 0, 0, 0, 1, 1, 0);
        check("t5.err9", int'(err_o), 1);
        check("t5.novend9", int'(vend_valid_o), 0);
`ifdef VM_RESTOCK_EN
        rs = 1; rsp = 1;
        cyc("t5.restock", 0, 0, 0, 0, 0, 0, 0);
        check("t5.restocked", int'(sold_out_o[1]), 0);
`endif
        cyc("t5.cancel", 0, 0, 0, 0, 0, 0, 1);
        drain("t5.drain");

        // 6: exact-price vend with a colliding quarter, then reset mid-refund
        cyc("t6.quarter", 0, 0, 0, 1, 0, 0, 0);
        cyc("t6.nickel", 0, 1, 0, 0, 0, 0, 0);
        check("t6.credit6", int'(credit_o), 6);
        cyc("t6.sel2q", 0, 0, 0, 1, 1, 2, 0);
        check("t6.vend", int'(vend_valid_o), 1);
        check("t6.reject", int'(coin_reject_o), 1);
        check("t6.credit0", int'(credit_o), 0);
        cyc("t6.idle", 0, 0, 0, 0, 0, 0, 0);
        check("t6.nochange", int'(change_o), 0);
        cyc("t6.q1", 0, 0, 0, 1, 0, 0, 0);
        cyc("t6.q2", 0, 0, 0, 1, 0, 0, 0);
        cyc("t6.sel0", 0, 0, 0, 0, 1, 0, 0);
        cyc("t6.chg1", 0, 0, 0, 0, 0, 0, 0);
        cyc("t6.chg2", 0, 0, 0, 0, 0, 0, 0);
        check("t6.in_change", int'(change_o), 1);
        cyc("t6.rst", 1, 0, 0, 0, 0, 0, 0);
        check("t6.rst_credit", int'(credit_o), 0);
        check("t6.rst_change", int'(change_o), 0);
        check("t6.rst_busy", int'(busy_o), 0);
        check("t6.rst_soldout", int'(sold_out_o), 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 299) == 0);
            cp = $urandom_range(0, 9);
            n  = (cp == 6); d = (cp == 7); qt = (cp == 8);
            if (cp == 9) begin
                n  = $urandom_range(0, 1);
                d  = $urandom_range(0, 1);
                qt = !(n && d) ? 1'b1 : $urandom_range(0, 1);
                if (!n && !d) n = 1;
            end
            sv = ($urandom_range(0, 99) < 15);
            s  = $urandom_range(0, NP - 1);
            c  = ($urandom_range(0, 99) < 5);
`ifdef VM_RESTOCK_EN
            rs  = ($urandom_range(0, 99) < 2);
            rsp = $urandom_range(0, NP - 1);
`endif
            cyc("rand", r, n, d, qt, sv, s, c);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
